// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port registered-read word memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (rq0 wins).
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_req,
    input  logic              rq0_write,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ack,
    output logic [DATA_W-1:0] rq0_rdata,
    input  logic              rq1_req,
    input  logic              rq1_write,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ack,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              mem_ce,
    output logic              mem_sel,
    output logic              mem_pwrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_grant, w_grant_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                r_is_write, w_is_write_nxt;
    logic                r_mem_ce, w_mem_ce_nxt;
    logic                r_mem_sel, w_mem_sel_nxt;
    logic                r_mem_pwrite, w_mem_pwrite_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wr_data, w_mem_wr_data_nxt;
    logic                r_rq0_ack, w_rq0_ack_nxt;
    logic                r_rq1_ack, w_rq1_ack_nxt;
    logic [DATA_W-1:0]   r_rq0_rdata, w_rq0_rdata_nxt;
    logic [DATA_W-1:0]   r_rq1_rdata, w_rq1_rdata_nxt;
    logic                w_win;

    // w_win: 0 selects rq0, 1 selects rq1; only meaningful when some request is high.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (rq0_req && rq1_req) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = ~rq0_req;
        end
`else
        w_win = ~rq0_req;
`endif
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_last_grant_nxt  = r_last_grant;
        w_is_write_nxt    = r_is_write;
        w_mem_ce_nxt      = 1'b0;
        w_mem_sel_nxt     = 1'b1;
        w_mem_pwrite_nxt  = 1'b0;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wr_data_nxt = r_mem_wr_data;
        w_rq0_ack_nxt     = 1'b0;
        w_rq1_ack_nxt     = 1'b0;
        w_rq0_rdata_nxt   = r_rq0_rdata;
        w_rq1_rdata_nxt   = r_rq1_rdata;

        case (r_state)
            IDLE: begin
                if (rq0_req || rq1_req) begin
                    w_grant_nxt       = w_win;
                    w_last_grant_nxt  = w_win;
                    w_is_write_nxt    = w_win ? rq1_write : rq0_write;
                    w_mem_ce_nxt      = 1'b1;
                    w_mem_sel_nxt     = 1'b0;
                    w_mem_pwrite_nxt  = w_win ? rq1_write : rq0_write;
                    w_mem_addr_nxt    = w_win ? rq1_addr  : rq0_addr;
                    w_mem_wr_data_nxt = w_win ? rq1_wdata : rq0_wdata;
                    w_state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            // Registered memory read data is valid during WAIT.
            WAIT: begin
                if (!r_is_write) begin
                    if (r_grant) begin
                        w_rq1_rdata_nxt = mem_rd_data;
                    end else begin
                        w_rq0_rdata_nxt = mem_rd_data;
                    end
                end
                w_rq0_ack_nxt = ~r_grant;
                w_rq1_ack_nxt = r_grant;
                w_state_nxt   = RESP;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_is_write    <= 1'b0;
            r_mem_ce      <= 1'b0;
            r_mem_sel     <= 1'b1;
            r_mem_pwrite  <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_rq0_ack     <= 1'b0;
            r_rq1_ack     <= 1'b0;
            r_rq0_rdata   <= '0;
            r_rq1_rdata   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_is_write    <= w_is_write_nxt;
            r_mem_ce      <= w_mem_ce_nxt;
            r_mem_sel     <= w_mem_sel_nxt;
            r_mem_pwrite  <= w_mem_pwrite_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wr_data <= w_mem_wr_data_nxt;
            r_rq0_ack     <= w_rq0_ack_nxt;
            r_rq1_ack     <= w_rq1_ack_nxt;
            r_rq0_rdata   <= w_rq0_rdata_nxt;
            r_rq1_rdata   <= w_rq1_rdata_nxt;
        end
    end

    assign mem_ce      = r_mem_ce;
    assign mem_sel     = r_mem_sel;
    assign mem_pwrite  = r_mem_pwrite;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign rq0_ack     = r_rq0_ack;
    assign rq1_ack     = r_rq1_ack;
    assign rq0_rdata   = r_rq0_rdata;
    assign rq1_rdata   = r_rq1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 256x32 registered-read memory.
// Memory word i is preloaded with i + 10.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rq0_req = 1'b0, rq0_write = 1'b0;
    logic [7:0]  rq0_addr = '0;
    logic [31:0] rq0_wdata = '0;
    logic        rq0_ack;
    logic [31:0] rq0_rdata;
    logic        rq1_req = 1'b0, rq1_write = 1'b0;
    logic [7:0]  rq1_addr = '0;
    logic [31:0] rq1_wdata = '0;
    logic        rq1_ack;
    logic [31:0] rq1_rdata;
    logic        mem_ce, mem_sel, mem_pwrite;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = '0;

    logic [31:0] mem [256];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .rq0_req(rq0_req), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
        .rq1_req(rq1_req), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
        .mem_ce(mem_ce), .mem_sel(mem_sel), .mem_pwrite(mem_pwrite),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_ce && !mem_sel) begin
            if (mem_pwrite) mem[mem_addr] <= mem_wr_data;
            else            mem_rd_data  <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_txn(input bit port, input bit wr, input logic [7:0] addr,
                           input logic [31:0] wdata, output int lat, output int ack_cyc,
                           output logic [31:0] rd, output bit strobe_ok, output bit other_quiet);
        @(negedge clk);
        if (port) begin
            rq1_req = 1'b1; rq1_write = wr; rq1_addr = addr; rq1_wdata = wdata;
        end else begin
            rq0_req = 1'b1; rq0_write = wr; rq0_addr = addr; rq0_wdata = wdata;
        end
        lat = -1; ack_cyc = -1; rd = '0; strobe_ok = 1'b1; other_quiet = 1'b1;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!(mem_ce && !mem_sel && mem_pwrite == wr && mem_addr == addr &&
                      (!wr || mem_wr_data == wdata)))
                    strobe_ok = 1'b0;
            end else if (mem_ce || !mem_sel) begin
                strobe_ok = 1'b0;
            end
            if (port ? rq0_ack : rq1_ack) other_quiet = 1'b0;
            if (port ? rq1_ack : rq0_ack) begin
                lat = c; ack_cyc = cyc; rd = port ? rq1_rdata : rq0_rdata;
                rq0_req = 1'b0; rq1_req = 1'b0;
            end
        end
        rq0_req = 1'b0; rq1_req = 1'b0;
    endtask

    typedef struct {
        bit          port;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int          lat, ack_cyc, prev_ack;
        logic [31:0] rd;
        bit          sok, oq;
        int          a0_cyc, a1_cyc;
        logic [31:0] a0_d, a1_d;
        int          n_acks;
        int          ack_port[4], ack_c[4];
        logic [31:0] ack_d[4];
        int          exp_port[4];
        int          bad;

        for (int i = 0; i < 256; i++) mem[i] = 32'(i + 10);

        tbl[0] = '{1'b0, 1'b0, 8'h05, 32'h0,        32'h0000000F};
        tbl[1] = '{1'b1, 1'b1, 8'h01, 32'h04108042, 32'h00000000};
        tbl[2] = '{1'b1, 1'b0, 8'h01, 32'h0,        32'h04108042};
        tbl[3] = '{1'b0, 1'b1, 8'hFF, 32'hDEADBEEF, 32'h0000000F};
        tbl[4] = '{1'b0, 1'b0, 8'hFF, 32'h0,        32'hDEADBEEF};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h0000000A};
        tbl[6] = '{1'b0, 1'b0, 8'h80, 32'h0,        32'h0000008A};

        repeat (2) @(negedge clk);
        check("reset_ctrl", {mem_ce, mem_sel, mem_pwrite, mem_addr, rq0_ack, rq1_ack},
              {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        check("reset_wr_data", mem_wr_data, 32'h0);
        check("reset_rdata", {rq0_rdata, rq1_rdata}, 64'h0);
        rst = 1'b0;

        prev_ack = -1;
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, ack_cyc, rd, sok, oq);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_strobes", i), sok, 1);
            check($sformatf("vec%0d_other_ack", i), oq, 1);
            if (i > 0) check($sformatf("vec%0d_ack_gap", i), ack_cyc - prev_ack, 4);
            prev_ack = ack_cyc;
        end

        // Simultaneous reads: rq0 addr 0x00, rq1 addr 0x02.
        pulse_reset();
        @(negedge clk);
        rq0_req = 1'b1; rq0_write = 1'b0; rq0_addr = 8'h00;
        rq1_req = 1'b1; rq1_write = 1'b0; rq1_addr = 8'h02;
        a0_cyc = -1; a1_cyc = -1; a0_d = '0; a1_d = '0;
        for (int c = 1; c <= 12 && a1_cyc < 0; c++) begin
            @(negedge clk);
            if (rq0_ack) begin a0_cyc = c; a0_d = rq0_rdata; rq0_req = 1'b0; end
            if (rq1_ack) begin a1_cyc = c; a1_d = rq1_rdata; rq1_req = 1'b0; end
        end
        rq0_req = 1'b0; rq1_req = 1'b0;
        check("tie_rq0_cycle", a0_cyc, 3);
        check("tie_rq0_rdata", a0_d, 32'h0000000A);
        check("tie_rq1_cycle", a1_cyc, 7);
        check("tie_rq1_rdata", a1_d, 32'h0000000C);

        // Both held; rq0 drops after its ack in cycle 11, rq1 after the fourth ack.
        pulse_reset();
        @(negedge clk);
        rq0_req = 1'b1; rq0_write = 1'b0; rq0_addr = 8'h03;
        rq1_req = 1'b1; rq1_write = 1'b0; rq1_addr = 8'h04;
        n_acks = 0;
        for (int i = 0; i < 4; i++) begin ack_port[i] = -1; ack_c[i] = -1; ack_d[i] = '0; end
        for (int c = 1; c <= 24 && n_acks < 4; c++) begin
            @(negedge clk);
            if (rq0_ack && n_acks < 4) begin
                ack_port[n_acks] = 0; ack_c[n_acks] = c; ack_d[n_acks] = rq0_rdata; n_acks++;
                if (c >= 11) rq0_req = 1'b0;
            end
            if (rq1_ack && n_acks < 4) begin
                ack_port[n_acks] = 1; ack_c[n_acks] = c; ack_d[n_acks] = rq1_rdata; n_acks++;
            end
        end
        rq0_req = 1'b0; rq1_req = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_port = '{0, 1, 0, 1};
`else
        exp_port = '{0, 0, 0, 1};
`endif
        check("hold_ack_count", n_acks, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold%0d_port", i), ack_port[i], exp_port[i]);
            check($sformatf("hold%0d_cycle", i), ack_c[i], 4 * i + 3);
            check($sformatf("hold%0d_rdata", i), ack_d[i],
                  (exp_port[i] == 1) ? 32'h0000000E : 32'h0000000D);
        end

        // Reset during WAIT of an rq0 read, request kept high and re-served.
        @(negedge clk);
        rq0_req = 1'b1; rq0_write = 1'b0; rq0_addr = 8'h07;
        bad = 0;
        @(negedge clk);
        if (rq0_ack || rq1_ack) bad++;
        @(negedge clk);
        if (rq0_ack || rq1_ack) bad++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_early_ack", bad, 0);
        check("midrst_ctrl", {mem_ce, mem_sel, mem_pwrite, mem_addr, rq0_ack, rq1_ack},
              {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        check("midrst_data", {mem_wr_data, rq0_rdata, rq1_rdata}, 96'h0);
        lat = -1; rd = '0;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            if (rq0_ack) begin lat = c; rd = rq0_rdata; rq0_req = 1'b0; end
        end
        rq0_req = 1'b0;
        check("midrst_reissue_latency", lat, 3);
        check("midrst_reissue_rdata", rd, 32'h00000011);

        // Idle window: no strobes, no acks.
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_ce || !mem_sel || rq0_ack || rq1_ack) bad++;
        end
        check("idle20_quiet_cycles_bad", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the 256x32 single-port word memory (ce / active-low sel / pwrite interface, registered read data).
- Shares the memory between requester 0 (processor load/store path) and requester 1 (RTC load/store-back engine).
- Converts each requester's req/ack handshake into correctly timed memory strobes and returns read data with the ack.

Parameters:
ADDR_W, 8, memory word-address width
DATA_W, 32, data width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
rq0_req  input  1  requester 0 request; held until rq0_ack
rq0_write  input  1  1=write, 0=read; stable while req
rq0_addr  input  ADDR_W  word address; stable while req
rq0_wdata  input  DATA_W  write data; stable while req
rq0_ack  output  1  one-cycle completion pulse
rq0_rdata  output  DATA_W  read data; valid in ack cycle, held until the next rq0 read ack
rq1_req, rq1_write, rq1_addr, rq1_wdata, rq1_ack, rq1_rdata  same as rq0_* for requester 1
mem_ce  output  1  memory chip enable
mem_sel  output  1  memory select, active-low (0 = access)
mem_pwrite  output  1  memory write strobe qualifier
mem_addr  output  ADDR_W  memory address
mem_wr_data  output  DATA_W  memory write data
mem_rd_data  input  DATA_W  memory registered read data

Behaviour:
- All outputs are registered.
- Reset values: mem_ce=0, mem_sel=1, mem_pwrite=0, mem_addr=0, mem_wr_data=0, rqN_ack=0, rqN_rdata=0, state=IDLE, last_grant=1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, pick a winner, latch grant, and at the edge set mem_ce=1, mem_sel=0, and load mem_pwrite/mem_addr/mem_wr_data from the winner; go to ISSUE. With no request, stay in IDLE with mem_ce=0, mem_sel=1.
- ISSUE (one cycle): strobes are stable, so the memory performs the access at the closing edge. At that edge drop mem_ce to 0 and mem_sel to 1, clear mem_pwrite, and go to WAIT.
- WAIT (one cycle): mem_rd_data is valid. At the edge:
  - read: the granted rqN_rdata takes mem_rd_data;
  - write: rqN_rdata is unchanged;
  - in both cases the granted rqN_ack goes to 1 and the state moves to RESP.
- RESP (one cycle): rqN_ack=1 for the granted port only. At the edge ack returns to 0 and the state returns to IDLE.
- Latency: req first high in cycle 0 (IDLE) gives ack high in cycle 3. Reads and writes take the same time.
- Throughput: a requester may present its next request in the cycle after ack, giving one transaction every 4 cycles at best.
- Fixed priority (default): when both requests are high in IDLE, rq0 wins. last_grant is still updated.
- Only one transaction is in flight at a time. A request arriving in a non-IDLE state waits; it is never dropped.
- A request deasserted before ack is a protocol violation; its behaviour is undefined.
- Memory strobes are never asserted in IDLE, WAIT or RESP. mem_ce=1 occurs only together with mem_sel=0.
- rqN_ack of the non-granted port is always 0.
- Reset mid-operation:
  - next state IDLE, all outputs at reset values, no ack issued.
  - A strobe already registered in ISSUE is still sampled by the memory at the reset edge, so that single access may complete. Requesters must re-issue after reset.
- Address wrap: none. The address passes through unmodified.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request the port not equal to last_grant wins. last_grant updates on every grant and resets to 1, so rq0 wins the first tie after reset.
- Undefined: fixed priority, rq0 always wins ties. last_grant logic is present but does not affect selection.

Test Plan:
- rq0 read addr 0x05 alone at cycle 0 -> mem_ce=1 and mem_sel=0 only in cycle 1; rq0_ack=1 in cycle 3 with rq0_rdata=0x0000000F; rq1_ack stays 0.
- rq1 write addr 0x01 data 0x04108042, then rq1 read addr 0x01 in the cycle after ack -> second ack 4 cycles after the first, rdata=0x04108042.
- Both reqs high at cycle 0, both read addr 0x00 and 0x02 respectively:
  - fixed priority: rq0_ack cycle 3 with 0x0000000A, then rq1_ack cycle 7 with 0x0000000C;
  - MEM_ARB_RR_EN: same first pair; with both held continuously, grants alternate rq0, rq1, rq0.
- rq0 held high continuously with rq1 high (MEM_ARB_RR_EN defined) -> rq1 served within 8 cycles; without the macro rq1 waits until rq0 drops.
- rst asserted in the WAIT cycle of an rq0 read -> no rq0_ack, outputs at reset values next cycle; re-issued read completes normally 3 cycles later.
- Idle for 20 cycles with no requests -> mem_ce=0 and mem_sel=1 throughout, no acks.
